spi_cmd_sequencer: RTL

//  Command-level controller for the SPI slave byte datapath. Consumes received-byte strobes,

---
 rtl/spi_seq_pkg.sv | 24 ++
 rtl/spi_seq_addr_ctr.sv | 35 +++
 rtl/spi_cmd_sequencer.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/spi_seq_pkg.sv
// Shared types and constants for the SPI command sequencer: FSM states, opcodes,
// the fill byte and the status byte layout.
package spi_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    WDATA,
    RDATA,
    DISCARD
  } state_t;

  localparam logic [7:0] OP_WRITE  = 8'h02;
  localparam logic [7:0] OP_READ   = 8'h03;
  localparam logic [7:0] OP_STATUS = 8'h05;
  localparam logic [7:0] FILL_BYTE = 8'hFF;

  // Status byte: bit 7 = sticky command error, bit 0 = always 1 (device present).
  function automatic logic [7:0] status_byte(input logic err);
    return {err, 6'b000000, 1'b1};
  endfunction

endpackage

// File: rtl/spi_seq_addr_ctr.sv
// Register address counter: load, advance with modulo-NUM_REGS wrap.
// Advancing is only honoured when SPI_SEQ_AUTOINC_EN is defined; otherwise the address stays put.
module spi_seq_addr_ctr #(
  parameter int ADDR_W   = 4,
  parameter int NUM_REGS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              advance,
  output logic [ADDR_W-1:0] addr
);

`ifdef SPI_SEQ_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

  // NOTE: sequential state uses non-blocking assignments and a synchronous reset
  // tested first, so every register sees the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr <= '0;
    end else if (load) begin
      addr <= load_addr;
    end else if (advance && AUTOINC) begin
      addr <= (addr == LAST_ADDR) ? '0 : addr + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/spi_cmd_sequencer.sv
// Command-level SPI slave sequencer: opcode + address decode, register file access and
// transmit preload. Burst address increment is enabled by defining SPI_SEQ_AUTOINC_EN.
module spi_cmd_sequencer
  import spi_seq_pkg::*;
#(
  parameter int ADDR_W   = 4,
  parameter int NUM_REGS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_active,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              tx_load,
  output logic [7:0]        tx_data,
  output logic [ADDR_W-1:0] reg_addr,
  input  logic [7:0]        reg_rdata,
  output logic              reg_wr_en,
  output logic [7:0]        reg_wdata,
  output logic              busy,
  output logic              cmd_err
);

  state_t     state;
  logic       frame_q;
  logic       is_read;
  logic       status_mode;
  logic       clr_pending;
  logic       rd_sel;
  logic [7:0] tx_data_q;
  logic       addr_load;
  logic       addr_advance;

  // Register-read loads present reg_rdata for the freshly updated address in the load
  // cycle, then tx_data_q captures it so tx_data stays stable afterwards.
  assign tx_data = rd_sel ? reg_rdata : tx_data_q;
  assign busy    = (state != IDLE);

  assign addr_load    = (state == ADDR) && rx_valid && frame_active;
  // Writes advance in the strobe cycle so the write lands on the pre-advance address.
  assign addr_advance = reg_wr_en ||
                        ((state == RDATA) && rx_valid && frame_active && !status_mode);

  spi_seq_addr_ctr #(
    .ADDR_W  (ADDR_W),
    .NUM_REGS(NUM_REGS)
  ) u_addr_ctr (
    .clk      (clk),
    .rst      (rst),
    .load     (addr_load),
    .load_addr(rx_data[ADDR_W-1:0]),
    .advance  (addr_advance),
    .addr     (reg_addr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      // NOTE: frame_q resets high so a frame already active across reset is not
      // mistaken for a start edge; a fresh 0->1 transition is required.
      frame_q     <= 1'b1;
      is_read     <= 1'b0;
      status_mode <= 1'b0;
      clr_pending <= 1'b0;
      rd_sel      <= 1'b0;
      tx_data_q   <= 8'h00;
      tx_load     <= 1'b0;
      reg_wr_en   <= 1'b0;
      reg_wdata   <= 8'h00;
      cmd_err     <= 1'b0;
    end else begin
      frame_q     <= frame_active;
      tx_load     <= 1'b0;
      reg_wr_en   <= 1'b0;
      clr_pending <= 1'b0;
      if (rd_sel) begin
        tx_data_q <= reg_rdata;
        rd_sel    <= 1'b0;
      end
      if (clr_pending) cmd_err <= 1'b0;

      if (!frame_active) begin
        state       <= IDLE;
        status_mode <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (!frame_q) begin
              tx_load   <= 1'b1;
              tx_data_q <= status_byte(cmd_err);
              state     <= CMD;
            end
          end
          CMD: begin
            if (rx_valid) begin
              unique case (rx_data)
                OP_WRITE: begin
                  is_read <= 1'b0;
                  state   <= ADDR;
                end
                OP_READ: begin
                  is_read <= 1'b1;
                  state   <= ADDR;
                end
                OP_STATUS: begin
                  tx_load     <= 1'b1;
                  tx_data_q   <= status_byte(cmd_err);
                  status_mode <= 1'b1;
                  clr_pending <= 1'b1;
                  state       <= RDATA;
                end
                default: begin
                  cmd_err   <= 1'b1;
                  tx_data_q <= FILL_BYTE;
                  state     <= DISCARD;
                end
              endcase
            end
          end
          ADDR: begin
            if (rx_valid) begin
              if (int'(rx_data) >= NUM_REGS) begin
                cmd_err   <= 1'b1;
                tx_data_q <= FILL_BYTE;
                rd_sel    <= 1'b0;
                state     <= DISCARD;
              end else if (is_read) begin
                tx_load <= 1'b1;
                rd_sel  <= 1'b1;
                state   <= RDATA;
              end else begin
                state <= WDATA;
              end
            end
          end
          WDATA: begin
            if (rx_valid) begin
              reg_wr_en <= 1'b1;
              reg_wdata <= rx_data;
            end
          end
          RDATA: begin
            if (rx_valid) begin
              tx_load <= 1'b1;
              if (status_mode) begin
                tx_data_q   <= status_byte(cmd_err);
                clr_pending <= 1'b1;
              end else begin
                rd_sel <= 1'b1;
              end
            end
          end
          DISCARD: begin
            tx_data_q <= FILL_BYTE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
